// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between the core's io_master port and axi4_sram_slave.
// Signal names keep the io_ prefix of the original flat port list.
interface axi4_sram_slave_if;
    logic        io_awvalid;
    logic        io_awready;
    logic [31:0] io_awaddr;
    logic [3:0]  io_awid;
    logic [7:0]  io_awlen;
    logic [2:0]  io_awsize;
    logic [1:0]  io_awburst;

    logic        io_wvalid;
    logic        io_wready;
    logic [63:0] io_wdata;
    logic [7:0]  io_wstrb;
    logic        io_wlast;

    logic        io_bvalid;
    logic        io_bready;
    logic [1:0]  io_bresp;
    logic [3:0]  io_bid;

    logic        io_arvalid;
    logic        io_arready;
    logic [31:0] io_araddr;
    logic [3:0]  io_arid;
    logic [7:0]  io_arlen;
    logic [2:0]  io_arsize;
    logic [1:0]  io_arburst;

    logic        io_rvalid;
    logic        io_rready;
    logic [63:0] io_rdata;
    logic [1:0]  io_rresp;
    logic        io_rlast;
    logic [3:0]  io_rid;

    modport master (
        output io_awvalid, io_awaddr, io_awid, io_awlen, io_awsize, io_awburst,
        input  io_awready,
        output io_wvalid, io_wdata, io_wstrb, io_wlast,
        input  io_wready,
        input  io_bvalid, io_bresp, io_bid,
        output io_bready,
        output io_arvalid, io_araddr, io_arid, io_arlen, io_arsize, io_arburst,
        input  io_arready,
        input  io_rvalid, io_rdata, io_rresp, io_rlast, io_rid,
        output io_rready
    );

    modport slave (
        input  io_awvalid, io_awaddr, io_awid, io_awlen, io_awsize, io_awburst,
        output io_awready,
        input  io_wvalid, io_wdata, io_wstrb, io_wlast,
        output io_wready,
        output io_bvalid, io_bresp, io_bid,
        input  io_bready,
        input  io_arvalid, io_araddr, io_arid, io_arlen, io_arsize, io_arburst,
        output io_arready,
        output io_rvalid, io_rdata, io_rresp, io_rlast, io_rid,
        input  io_rready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a 2^DEPTH_LOG2 x 64-bit SRAM array, one transaction
// in flight at a time (reads win over writes in IDLE).
// Optional feature: define AXI4_SRAM_WRAP_EN to support WRAP bursts
// (len 1/3/7/15, size-aligned start); otherwise WRAP answers SLVERR.
module axi4_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic             clock,
    input  logic             reset,
    axi4_sram_slave_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(WORDS) << 3;
`ifdef AXI4_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [63:0] mem [WORDS];

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [3:0]  id_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        dec_q;
    logic        slv_q;
    logic [7:0]  beat_q;
    logic [8:0]  wcnt_q;
    logic        wdec_q;
    logic [1:0]  bresp_q;

    logic [31:0]           cur_off;
    logic                  cur_oor;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  in_burst;
    logic                  ar_fire;
    logic                  aw_fire;
    logic                  mem_we;

    function automatic logic out_of_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return {1'b0, off} >= SPAN;
    endfunction

    function automatic logic req_slverr(input logic [31:0] a, input logic [7:0] l,
                                        input logic [2:0] s, input logic [1:0] b);
        logic bad;
        logic wrap_ok;
        wrap_ok = (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15) &&
                  ((a & ((32'd1 << s) - 32'd1)) == 32'd0);
        bad = (s > 3'd3) || (b == 2'b11);
        if (b == 2'b10) begin
            if (WRAP_EN) bad = bad || !wrap_ok;
            else         bad = 1'b1;
        end
        return bad;
    endfunction

    // WRAP keeps the upper bits of the aligned (len+1)<<size window and lets
    // only the in-window offset advance.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] l,
                                              input logic [2:0] s, input logic [1:0] b);
        logic [31:0] sum;
        logic [31:0] mask;
        sum  = a + (32'd1 << s);
        mask = ((32'(l) + 32'd1) << s) - 32'd1;
        if (b == 2'b00)
            return a;
        else if (b == 2'b10 && WRAP_EN)
            return (a & ~mask) | (sum & mask);
        else
            return sum;
    endfunction

    assign cur_off  = addr_q - BASE_ADDR;
    assign cur_oor  = {1'b0, cur_off} >= SPAN;
    assign widx     = cur_off[DEPTH_LOG2+2:3];
    assign in_burst = wcnt_q <= {1'b0, len_q};
    assign ar_fire  = (state_q == IDLE) && bus.io_arvalid;
    assign aw_fire  = (state_q == IDLE) && !bus.io_arvalid && bus.io_awvalid;
    assign mem_we   = (state_q == WR) && bus.io_wvalid && in_burst &&
                      !dec_q && !slv_q && !cur_oor;

    // Next-state and all bus outputs; everything idles at zero during reset.
    always_comb begin
        state_d        = state_q;
        bus.io_awready = 1'b0;
        bus.io_arready = 1'b0;
        bus.io_wready  = 1'b0;
        bus.io_bvalid  = 1'b0;
        bus.io_bresp   = RESP_OKAY;
        bus.io_bid     = '0;
        bus.io_rvalid  = 1'b0;
        bus.io_rdata   = '0;
        bus.io_rresp   = RESP_OKAY;
        bus.io_rlast   = 1'b0;
        bus.io_rid     = '0;
        unique case (state_q)
            IDLE: begin
                bus.io_arready = !reset;
                bus.io_awready = !reset && !bus.io_arvalid;
                if (ar_fire)      state_d = RD;
                else if (aw_fire) state_d = WR;
            end
            RD: begin
                bus.io_rvalid = 1'b1;
                bus.io_rid    = id_q;
                bus.io_rlast  = (beat_q == len_q);
                if (dec_q || cur_oor)
                    bus.io_rresp = RESP_DECERR;
                else if (slv_q)
                    bus.io_rresp = RESP_SLVERR;
                else
                    bus.io_rdata = mem[widx];
                if (bus.io_rready && bus.io_rlast) state_d = IDLE;
            end
            WR: begin
                bus.io_wready = 1'b1;
                if (bus.io_wvalid && bus.io_wlast) state_d = WRESP;
            end
            WRESP: begin
                bus.io_bvalid = 1'b1;
                bus.io_bid    = id_q;
                bus.io_bresp  = bresp_q;
                if (bus.io_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus request latching and per-beat address/count tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            dec_q   <= 1'b0;
            slv_q   <= 1'b0;
            beat_q  <= '0;
            wcnt_q  <= '0;
            wdec_q  <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (ar_fire) begin
                        addr_q  <= bus.io_araddr;
                        id_q    <= bus.io_arid;
                        len_q   <= bus.io_arlen;
                        size_q  <= bus.io_arsize;
                        burst_q <= bus.io_arburst;
                        dec_q   <= out_of_range(bus.io_araddr);
                        slv_q   <= req_slverr(bus.io_araddr, bus.io_arlen,
                                              bus.io_arsize, bus.io_arburst);
                        beat_q  <= '0;
                    end else if (aw_fire) begin
                        addr_q  <= bus.io_awaddr;
                        id_q    <= bus.io_awid;
                        len_q   <= bus.io_awlen;
                        size_q  <= bus.io_awsize;
                        burst_q <= bus.io_awburst;
                        dec_q   <= out_of_range(bus.io_awaddr);
                        slv_q   <= req_slverr(bus.io_awaddr, bus.io_awlen,
                                              bus.io_awsize, bus.io_awburst);
                        wcnt_q  <= '0;
                        wdec_q  <= 1'b0;
                    end
                end
                RD: begin
                    if (bus.io_rready) begin
                        beat_q <= beat_q + 8'd1;
                        addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
                    end
                end
                WR: begin
                    if (bus.io_wvalid) begin
                        // Saturating count: excess beats past awlen are only
                        // counted, never written.
                        if (wcnt_q != '1) wcnt_q <= wcnt_q + 9'd1;
                        addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
                        if (in_burst && cur_oor) wdec_q <= 1'b1;
                        if (bus.io_wlast) begin
                            if (dec_q || wdec_q || (in_burst && cur_oor))
                                bresp_q <= RESP_DECERR;
                            else if (slv_q || (wcnt_q != {1'b0, len_q}))
                                bresp_q <= RESP_SLVERR;
                            else
                                bresp_q <= RESP_OKAY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-lane SRAM write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (bus.io_wstrb[i]) mem[widx][i*8 +: 8] <= bus.io_wdata[i*8 +: 8];
            end
        end
    end
endmodule
